iq_symbol_sched: RTL and testbench

//  Symbol scheduler and NCO for the IQ modulator datapath. Buffers I/Q amplitude

---
 rtl/tx_pkg.sv | 17 +
 rtl/sym_fifo.sv | 52 +++++
 rtl/iq_symbol_sched.sv | 128 ++++++++++++
 tb/tb_iq_symbol_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared state encoding and symbol constants for the IQ transmit path
package tx_pkg;

  localparam int SYM_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_UNDERRUN = 2'd2
  } state_e;

  // Symbol period counter reload value; sps of 0 behaves as 1.
  function automatic logic [7:0] sps_reload(input logic [7:0] sps);
    return (sps == 8'd0) ? 8'd0 : sps - 8'd1;
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// rtl/sym_fifo.sv - synchronous FIFO of packed {i,q} symbols with occupancy count
module sym_fifo
  import tx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [2*SYM_W-1:0] wdata,
  output logic [2*SYM_W-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        count
);

  logic [2*SYM_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        count_q;
  logic               push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_q];
  // A push is refused when full even if a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/iq_symbol_sched.sv
// rtl/iq_symbol_sched.sv - symbol scheduler and phase accumulator feeding the IQ modulator
module iq_symbol_sched
  import tx_pkg::*;
#(
  parameter int ACC_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PREFILL    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [ACC_W-1:0] ftw,
  input  logic [7:0]       sps,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym_i,
  input  logic [SYM_W-1:0] sym_q,
  output logic             sym_ready,
  output logic [7:0]       phase,
  output logic [SYM_W-1:0] i_mul,
  output logic [SYM_W-1:0] q_mul,
  output logic             sym_strobe,
  output logic             busy,
  output logic             underrun
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] PREFILL_C = CW'(PREFILL);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [SYM_W-1:0]   i_q, i_d, q_q, q_d;
  logic               strobe_q, strobe_d, under_q, under_d;
  logic               fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [2*SYM_W-1:0] fifo_head;

  sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sym_valid),
    .pop   (fifo_pop),
    .wdata ({sym_i, sym_q}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign sym_ready  = !fifo_full;
  assign phase      = acc_q[ACC_W-1 -: 8];
  assign i_mul      = i_q;
  assign q_mul      = q_q;
  assign sym_strobe = strobe_q;
  assign underrun   = under_q;
  assign busy       = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      i_q      <= '0;
      q_q      <= '0;
      strobe_q <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      i_q      <= i_d;
      q_q      <= q_d;
      strobe_q <= strobe_d;
      under_q  <= under_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    i_d      = i_q;
    q_d      = q_q;
    strobe_d = 1'b0;
    under_d  = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        i_d   = '0;
        q_d   = '0;
        if (enable && fifo_count >= PREFILL_C) begin
          state_d    = ST_RUN;
          fifo_pop   = 1'b1;
          {i_d, q_d} = fifo_head;
          strobe_d   = 1'b1;
          cnt_d      = sps_reload(sps);
        end
      end
      ST_RUN, ST_UNDERRUN: begin
        acc_d = acc_q + ftw;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!enable) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          i_d     = '0;
          q_d     = '0;
        end else if (!fifo_empty) begin
          state_d    = ST_RUN;
          fifo_pop   = 1'b1;
          {i_d, q_d} = fifo_head;
          strobe_d   = 1'b1;
          cnt_d      = sps_reload(sps);
        end else begin
          // Starved boundary: keep the symbol grid running with zero amplitude.
          state_d = ST_UNDERRUN;
          i_d     = '0;
          q_d     = '0;
          under_d = 1'b1;
          cnt_d   = sps_reload(sps);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_iq_symbol_sched.sv
// tb/tb_iq_symbol_sched.sv - randomized and directed checks of iq_symbol_sched against a queue model
module tb_iq_symbol_sched;

  localparam int DEPTH   = 8;
  localparam int PREFILL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] ftw = '0;
  logic [7:0]  sps = '0;
  logic        sym_valid = 1'b0;
  logic [7:0]  sym_i = '0, sym_q = '0;
  logic        sym_ready, sym_strobe, busy, underrun;
  logic [7:0]  phase, i_mul, q_mul;

  iq_symbol_sched dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .ftw        (ftw),
    .sps        (sps),
    .sym_valid  (sym_valid),
    .sym_i      (sym_i),
    .sym_q      (sym_q),
    .sym_ready  (sym_ready),
    .phase      (phase),
    .i_mul      (i_mul),
    .q_mul      (q_mul),
    .sym_strobe (sym_strobe),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: a queue of symbols, whether the symbol grid is running, and how many
  // clocks remain in the current symbol period.
  logic [15:0] m_fifo [$];
  bit          m_act;
  int          m_left;
  logic [15:0] m_acc;
  logic [7:0]  m_i, m_q;
  bit          m_stb, m_und;

  task automatic model_reset();
    m_fifo.delete();
    m_act = 0; m_left = 0; m_acc = '0;
    m_i = '0; m_q = '0; m_stb = 0; m_und = 0;
  endtask

  task automatic model_load(input int period);
    logic [15:0] head;
    head   = m_fifo.pop_front();
    m_i    = head[15:8];
    m_q    = head[7:0];
    m_stb  = 1;
    m_left = period;
  endtask

  task automatic model_step();
    int period;
    bit take;
    period = (sps == 8'd0) ? 1 : int'(sps);
    take   = sym_valid && (m_fifo.size() < DEPTH);
    m_stb  = 0;
    m_und  = 0;
    if (!m_act) begin
      m_acc = '0; m_i = '0; m_q = '0;
      if (enable && m_fifo.size() >= PREFILL) begin
        model_load(period);
        m_act = 1;
      end
    end else begin
      m_acc  = m_acc + ftw;
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (!enable) begin
          m_act = 0; m_acc = '0; m_i = '0; m_q = '0;
        end else if (m_fifo.size() > 0) begin
          model_load(period);
        end else begin
          m_i = '0; m_q = '0; m_und = 1; m_left = period;
        end
      end
    end
    if (take) m_fifo.push_back({sym_i, sym_q});
  endtask

  task automatic check_model();
    bit          e_rdy;
    logic [7:0]  e_ph;
    e_rdy = (m_fifo.size() < DEPTH);
    e_ph  = m_acc[15:8];
    n_vec++;
    if ({sym_ready, phase, i_mul, q_mul, sym_strobe, busy, underrun} !==
        {e_rdy, e_ph, m_i, m_q, m_stb, m_act, m_und}) begin
      n_err++;
      $display("FAIL model cycle %0d: got rdy=%0b ph=%02h i=%02h q=%02h stb=%0b busy=%0b und=%0b, want rdy=%0b ph=%02h i=%02h q=%02h stb=%0b busy=%0b und=%0b",
               cyc, sym_ready, phase, i_mul, q_mul, sym_strobe, busy, underrun,
               e_rdy, e_ph, m_i, m_q, m_stb, m_act, m_und);
    end
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, advance the model over the next
  // rising edge, then compare at the following falling edge.
  task automatic tick(input logic en, input logic v, input logic [7:0] si, input logic [7:0] sq,
                      input logic [7:0] sp, input logic [15:0] f);
    enable = en; sym_valid = v; sym_i = si; sym_q = sq; sps = sp; ftw = f;
    model_step();
    @(negedge clk);
    cyc++;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    lit("rst_busy", 16'(busy), 16'd0);
    lit("rst_imul", 16'(i_mul), 16'd0);
    lit("rst_ready", 16'(sym_ready), 16'd1);
    lit("rst_phase", 16'(phase), 16'd0);
    model_reset();
    @(negedge clk);
    cyc++;
    check_model();
    rst = 1'b0;
  endtask

  initial begin
    int          v_pct, en_low_pct, sps_max;
    logic [15:0] seg_ftw;
    logic [7:0]  sv;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lit("post_reset_ready", 16'(sym_ready), 16'd1);

    // Start-up with two prefilled symbols, sps=4, then starve and stop.
    tick(0, 1, 8'd10, 8'(-10), 8'd4, 16'h0100);
    tick(0, 1, 8'd20, 8'(-20), 8'd4, 16'h0100);
    for (int k = 0; k <= 16; k++) begin
      tick(k < 13, 0, 8'd0, 8'd0, 8'd4, 16'h0100);
      if (k < 8) begin
        lit("start_imul", 16'(i_mul), (k < 4) ? 16'd10 : 16'd20);
        lit("start_qmul", 16'(q_mul), (k < 4) ? 16'h00F6 : 16'h00EC);
        lit("start_phase", 16'(phase), 16'(k));
        lit("start_strobe", 16'(sym_strobe), 16'((k % 4) == 0));
      end
      if (k == 8 || k == 12) begin
        lit("starve_pulse", 16'(underrun), 16'd1);
        lit("starve_imul", 16'(i_mul), 16'd0);
      end
      if (k == 9) lit("starve_single", 16'(underrun), 16'd0);
      if (k == 15) lit("stop_busy_hold", 16'(busy), 16'd1);
      if (k == 16) lit("stop_busy", 16'(busy), 16'd0);
    end

    // Fill to full while idle, hold valid against backpressure, then drain at sps=0.
    for (int n = 1; n <= 8; n++) tick(0, 1, 8'(n), 8'(-n), 8'd0, 16'hFFFF);
    lit("full_ready", 16'(sym_ready), 16'd0);
    tick(0, 1, 8'd9, 8'(-9), 8'd0, 16'hFFFF);
    lit("full_hold_ready", 16'(sym_ready), 16'd0);
    tick(1, 1, 8'd9, 8'(-9), 8'd0, 16'hFFFF);
    lit("edge_first_imul", 16'(i_mul), 16'd1);
    lit("edge_first_phase", 16'(phase), 16'h00);
    lit("edge_ready_rise", 16'(sym_ready), 16'd1);
    tick(1, 1, 8'd9, 8'(-9), 8'd0, 16'hFFFF);
    lit("edge_second_imul", 16'(i_mul), 16'd2);
    lit("edge_wrap_phase", 16'(phase), 16'hFF);
    for (int n = 0; n < 10; n++) tick(1, 0, 8'd0, 8'd0, 8'd0, 16'hFFFF);
    repeat (2) tick(0, 0, 8'd0, 8'd0, 8'd0, 16'hFFFF);

    // Stop one clock into a 5-clock symbol; the queued head survives.
    tick(0, 1, 8'd30, 8'd3, 8'd5, 16'h0333);
    tick(0, 1, 8'd40, 8'd4, 8'd5, 16'h0333);
    tick(0, 1, 8'd50, 8'd5, 8'd5, 16'h0333);
    for (int k = 0; k <= 5; k++) begin
      tick(k == 0, 0, 8'd0, 8'd0, 8'd5, 16'h0333);
      if (k < 5) lit("stop_hold_imul", 16'(i_mul), 16'd30);
      if (k == 5) lit("stop_idle_busy", 16'(busy), 16'd0);
    end
    tick(1, 0, 8'd0, 8'd0, 8'd5, 16'h0333);
    lit("stop_head_kept", 16'(i_mul), 16'd40);

    // Randomized segments with a reset dropped into the middle of a run.
    for (int seg = 0; seg < 14; seg++) begin
      case ($urandom_range(0, 3))
        0: v_pct = 20;
        1: v_pct = 50;
        2: v_pct = 90;
        default: v_pct = 100;
      endcase
      en_low_pct = (seg % 3 == 0) ? 30 : ((seg % 3 == 1) ? 3 : 0);
      sps_max    = $urandom_range(0, 5);
      seg_ftw    = 16'($urandom);
      if (seg == 7) do_reset();
      for (int c = 0; c < 180; c++) begin
        sv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, sps_max)) : 8'(sps_max);
        tick($urandom_range(0, 99) >= en_low_pct,
             $urandom_range(0, 99) < v_pct,
             8'($urandom), 8'($urandom), sv, seg_ftw);
        if (seg == 4 && c == 90) do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
